// File: rtl/float_to_int.sv
// float_to_int: three-stage pipelined float -> signed integer converter.
//   S1 unpacks and classifies the float, S2 aligns the mantissa to integer
//   weight, S3 rounds, negates and saturates. All stages advance together
//   whenever the output register is empty or being consumed.
// Optional build macro FLOAT_TO_INT_ROUND_NEAREST_EN switches the default
// truncate-toward-zero behaviour to round-half-to-even.
module float_to_int #(
    parameter int MANTISSA_SIZE = 23,
    parameter int EXPONENT_SIZE = 8,
    parameter int INT_SIZE      = 32
) (
    input  logic                                 clk,
    input  logic                                 resetn,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [EXPONENT_SIZE+MANTISSA_SIZE:0] in_float,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [INT_SIZE-1:0]                  out_int,
    output logic                                 out_overflow
);

    localparam int FW    = 1 + EXPONENT_SIZE + MANTISSA_SIZE;
    localparam int MS_W  = MANTISSA_SIZE + 1;
    localparam int SH_W  = $clog2(INT_SIZE);
    // Unbiased exponent width: wide enough for the exponent range and for INT_SIZE-1.
    localparam int EW    = ((EXPONENT_SIZE > SH_W) ? EXPONENT_SIZE : SH_W) + 2;
    localparam int BIAS  = 2**(EXPONENT_SIZE-1) - 1;

    localparam logic signed [EW-1:0] E_BIAS = EW'(BIAS);
    localparam logic signed [EW-1:0] E_TOP  = EW'(INT_SIZE - 1);
    localparam logic signed [EW-1:0] E_MANT = EW'(MANTISSA_SIZE);
`ifdef FLOAT_TO_INT_ROUND_NEAREST_EN
    // 0.5 <= |x| < 1 must survive to the rounder.
    localparam logic signed [EW-1:0] E_LOW  = -EW'(1);
`else
    localparam logic signed [EW-1:0] E_LOW  = '0;
`endif

    localparam logic [INT_SIZE-1:0] INT_MAX = {1'b0, {(INT_SIZE-1){1'b1}}};
    localparam logic [INT_SIZE-1:0] INT_MIN = {1'b1, {(INT_SIZE-1){1'b0}}};

    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_NORMAL,
        CLS_EXACT_MIN,
        CLS_OVF,
        CLS_INF,
        CLS_NAN
    } cls_t;

    // Saturation limit for a given sign.
    function automatic logic [INT_SIZE-1:0] sat_limit(input logic neg);
        return neg ? INT_MIN : INT_MAX;
    endfunction

`ifdef FLOAT_TO_INT_ROUND_NEAREST_EN
    // Round-half-to-even on an unsigned magnitude using guard and sticky bits.
    function automatic logic [INT_SIZE-1:0] round_half_even(input logic [INT_SIZE-1:0] mag,
                                                            input logic grd,
                                                            input logic stk);
        return mag + INT_SIZE'(grd & (stk | mag[0]));
    endfunction
`endif

    logic advance;

    // Stage 1 signals
    logic                     sign_s1;
    logic [EXPONENT_SIZE-1:0] exp_s1;
    logic [MANTISSA_SIZE-1:0] man_s1;
    logic signed [EW-1:0]     e_s1;
    cls_t                     cls_s1;
    logic                     vld_p1_d, vld_p1_q;
    logic                     sign_p1_d, sign_p1_q;
    cls_t                     cls_p1_d, cls_p1_q;
    logic [MS_W-1:0]          src_p1_d, src_p1_q;
    logic signed [EW-1:0]     e_p1_d, e_p1_q;

    // Stage 2 signals
    logic [INT_SIZE-1:0]      src_w;
    logic [SH_W-1:0]          lsh;
    logic [SH_W-1:0]          rsh;
    logic [INT_SIZE-1:0]      mag_s2;
    logic                     vld_p2_d, vld_p2_q;
    logic                     sign_p2_d, sign_p2_q;
    cls_t                     cls_p2_d, cls_p2_q;
    logic [INT_SIZE-1:0]      mag_p2_d, mag_p2_q;
`ifdef FLOAT_TO_INT_ROUND_NEAREST_EN
    logic                     grd_s2, stk_s2;
    logic                     grd_p2_d, grd_p2_q;
    logic                     stk_p2_d, stk_p2_q;
`endif

    // Stage 3 signals
    logic [INT_SIZE-1:0]        mag_fin;
    logic signed [INT_SIZE-1:0] res_int;
    logic                       res_ovf;
    logic                       out_valid_d, out_valid_q;
    logic signed [INT_SIZE-1:0] out_int_d, out_int_q;
    logic                       out_ovf_d, out_ovf_q;

    assign advance      = ~out_valid_q | out_ready;
    assign in_ready     = advance;
    assign out_valid    = out_valid_q;
    assign out_int      = out_int_q;
    assign out_overflow = out_ovf_q;

    // S1: unpack fields, compute unbiased exponent and classify.
    always_comb begin
        sign_s1 = in_float[FW-1];
        exp_s1  = in_float[MANTISSA_SIZE +: EXPONENT_SIZE];
        man_s1  = in_float[MANTISSA_SIZE-1:0];
        e_s1    = $signed(EW'(exp_s1)) - E_BIAS;
        if (exp_s1 == '0) begin
            cls_s1 = CLS_ZERO;
        end else if (&exp_s1) begin
            cls_s1 = (man_s1 != '0) ? CLS_NAN : CLS_INF;
        end else if (e_s1 < E_LOW) begin
            cls_s1 = CLS_ZERO;
        end else if (e_s1 >= E_TOP) begin
            // -2^(INT_SIZE-1) is representable; every other value here is out of range.
            cls_s1 = (sign_s1 && (e_s1 == E_TOP) && (man_s1 == '0)) ? CLS_EXACT_MIN : CLS_OVF;
        end else begin
            cls_s1 = CLS_NORMAL;
        end
        vld_p1_d  = advance ? in_valid          : vld_p1_q;
        sign_p1_d = advance ? sign_s1           : sign_p1_q;
        cls_p1_d  = advance ? cls_s1            : cls_p1_q;
        src_p1_d  = advance ? {1'b1, man_s1}    : src_p1_q;
        e_p1_d    = advance ? e_s1              : e_p1_q;
    end

    // S2: align the mantissa to integer weight; fraction bits are dropped (or kept as guard/sticky).
    always_comb begin
        src_w  = INT_SIZE'(src_p1_q);
        lsh    = SH_W'(e_p1_q - E_MANT);
        rsh    = SH_W'(E_MANT - e_p1_q);
        mag_s2 = '0;
`ifdef FLOAT_TO_INT_ROUND_NEAREST_EN
        grd_s2 = 1'b0;
        stk_s2 = 1'b0;
`endif
        if (cls_p1_q == CLS_NORMAL) begin
            if (e_p1_q >= E_MANT) begin
                mag_s2 = src_w << lsh;
            end else begin
                mag_s2 = src_w >> rsh;
`ifdef FLOAT_TO_INT_ROUND_NEAREST_EN
                // rsh >= 1 here, so the guard is the highest dropped bit.
                grd_s2 = src_w[rsh - SH_W'(1)];
                stk_s2 = |(src_w & ((INT_SIZE'(1) << (rsh - SH_W'(1))) - INT_SIZE'(1)));
`endif
            end
        end
        vld_p2_d  = advance ? vld_p1_q  : vld_p2_q;
        sign_p2_d = advance ? sign_p1_q : sign_p2_q;
        cls_p2_d  = advance ? cls_p1_q  : cls_p2_q;
        mag_p2_d  = advance ? mag_s2    : mag_p2_q;
`ifdef FLOAT_TO_INT_ROUND_NEAREST_EN
        grd_p2_d  = advance ? grd_s2    : grd_p2_q;
        stk_p2_d  = advance ? stk_s2    : stk_p2_q;
`endif
    end

    // S3: round, apply sign, saturate and load the output register.
    always_comb begin
`ifdef FLOAT_TO_INT_ROUND_NEAREST_EN
        mag_fin = round_half_even(mag_p2_q, grd_p2_q, stk_p2_q);
`else
        mag_fin = mag_p2_q;
`endif
        res_int = '0;
        res_ovf = 1'b0;
        case (cls_p2_q)
            CLS_NORMAL: begin
                if (mag_fin[INT_SIZE-1]) begin
                    // Rounded up to 2^(INT_SIZE-1): exact for negatives, overflow for positives.
                    res_int = $signed(sat_limit(sign_p2_q));
                    res_ovf = ~sign_p2_q;
                end else begin
                    res_int = sign_p2_q ? -$signed(mag_fin) : $signed(mag_fin);
                end
            end
            CLS_EXACT_MIN: res_int = $signed(INT_MIN);
            CLS_OVF, CLS_INF: begin
                res_int = $signed(sat_limit(sign_p2_q));
                res_ovf = 1'b1;
            end
            CLS_NAN: begin
                res_int = $signed(INT_MAX);
                res_ovf = 1'b1;
            end
            default: begin
                res_int = '0;
                res_ovf = 1'b0;
            end
        endcase
        out_valid_d = advance ? vld_p2_q : out_valid_q;
        out_int_d   = advance ? res_int  : out_int_q;
        out_ovf_d   = advance ? res_ovf  : out_ovf_q;
    end

    // Control and output flops: cleared asynchronously so in-flight work is discarded.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld_p1_q    <= 1'b0;
            vld_p2_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_int_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            vld_p1_q    <= vld_p1_d;
            vld_p2_q    <= vld_p2_d;
            out_valid_q <= out_valid_d;
            out_int_q   <= out_int_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    // Internal datapath flops: qualified by the stage valids, so no reset needed.
    always_ff @(posedge clk) begin
        sign_p1_q <= sign_p1_d;
        cls_p1_q  <= cls_p1_d;
        src_p1_q  <= src_p1_d;
        e_p1_q    <= e_p1_d;
        sign_p2_q <= sign_p2_d;
        cls_p2_q  <= cls_p2_d;
        mag_p2_q  <= mag_p2_d;
`ifdef FLOAT_TO_INT_ROUND_NEAREST_EN
        grd_p2_q  <= grd_p2_d;
        stk_p2_q  <= stk_p2_d;
`endif
    end

endmodule
